// File: rtl/spi_master_if.sv
// Command-side bus of spi_master: command request/accept and read-data return.
// 'master' is the system requester, 'slave' is the spi_master core serving it.
interface spi_master_if;
    logic [9:0] cmd;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       busy;

    modport master (output cmd, cmd_valid, input cmd_ready, rd_data, rd_valid, busy);
    modport slave  (input cmd, cmd_valid, output cmd_ready, rd_data, rd_valid, busy);
endinterface

// File: rtl/spi_master.sv
// SPI mode-0 initiator for the SPI-slave/RAM subsystem: 10-bit commands out, 8-bit read data back.
// Optional SPI_MASTER_ABORT_EN adds an abort input that cuts a frame short into GUARD.
module spi_master #(
    parameter int CLK_DIV = 4,
    parameter int TURN    = 2
) (
    input  logic        clk,
    input  logic        rstn,
    spi_master_if.slave bus,
    output logic        SS_n,
    output logic        SCLK,
    output logic        MOSI,
    input  logic        MISO
`ifdef SPI_MASTER_ABORT_EN
    ,
    input  logic        abort,
    output logic        aborted
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_TX,
        S_TURN,
        S_RX,
        S_GUARD
    } state_t;

    localparam int CNT_W   = $clog2(2 * CLK_DIV) + 1;
    localparam int BIT_MAX = (TURN > 10) ? TURN : 10;
    localparam int BIT_W   = $clog2(BIT_MAX) + 1;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [BIT_W-1:0]   bit_cnt;
    logic               sclk_q;
    logic [9:0]         tx_sr;
    logic [6:0]         rx_sr;
    logic               rd_flag;
    logic [7:0]         rd_data_q;
    logic               rd_valid_q;

    logic active, half_done, fall, guard_done, accept, state_chg, rx_done, abort_go;

    assign active     = state inside {S_TX, S_TURN, S_RX};
    assign half_done  = cnt == CNT_W'(CLK_DIV - 1);
    assign fall       = active && sclk_q && half_done;
    assign guard_done = (state == S_GUARD) && (cnt == CNT_W'(2 * CLK_DIV - 1));
    assign accept     = (state == S_IDLE) && bus.cmd_valid;
    assign state_chg  = state_nxt != state;

`ifdef SPI_MASTER_ABORT_EN
    assign abort_go = abort && active;
`else
    assign abort_go = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // NOTE: every output of this block gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        state_nxt = state;
        rx_done   = 1'b0;
        unique case (state)
            S_IDLE:  if (bus.cmd_valid) state_nxt = S_TX;
            S_TX:    if (fall && bit_cnt == BIT_W'(9)) state_nxt = rd_flag ? S_TURN : S_GUARD;
            S_TURN:  if (fall && bit_cnt == BIT_W'(TURN - 1)) state_nxt = S_RX;
            S_RX:    if (fall && bit_cnt == BIT_W'(7)) begin
                         state_nxt = S_GUARD;
                         rx_done   = 1'b1;
                     end
            S_GUARD: if (guard_done) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        if (abort_go) begin
            state_nxt = S_GUARD;
            rx_done   = 1'b0;
        end
    end

    // Every state change restarts the half-period timer and SCLK low, so phases chain seamlessly.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt        <= '0;
            bit_cnt    <= '0;
            sclk_q     <= 1'b0;
            tx_sr      <= '0;
            rx_sr      <= '0;
            rd_flag    <= 1'b0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= rx_done;
            if (state_chg) begin
                cnt     <= '0;
                bit_cnt <= '0;
                sclk_q  <= 1'b0;
            end else if (active) begin
                if (half_done) begin
                    cnt    <= '0;
                    sclk_q <= !sclk_q;
                    if (sclk_q) bit_cnt <= bit_cnt + 1'b1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else if (state == S_GUARD) begin
                cnt <= cnt + 1'b1;
            end

            if (accept) begin
                tx_sr   <= bus.cmd;
                rd_flag <= bus.cmd[9:8] == 2'b11;
            end else if (state == S_TX && fall) begin
                tx_sr <= {tx_sr[8:0], 1'b0};
            end

            // The eighth bit goes straight into rd_data, so only seven are held.
            if (state == S_RX && fall) rx_sr <= {rx_sr[5:0], MISO};
            if (rx_done) rd_data_q <= {rx_sr, MISO};
        end
    end

`ifdef SPI_MASTER_ABORT_EN
    logic aborted_q;
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) aborted_q <= 1'b0;
        else       aborted_q <= abort_go;
    end
    assign aborted = aborted_q;
`endif

    assign bus.cmd_ready = state == S_IDLE;
    assign bus.busy      = state != S_IDLE;
    assign bus.rd_data   = rd_data_q;
    assign bus.rd_valid  = rd_valid_q;
    assign SS_n          = !active;
    assign SCLK          = sclk_q;
    assign MOSI          = (state == S_TX) && tx_sr[9];

endmodule
